// File: rtl/counter_preload_reg.sv
// counter_preload_reg
//   8-bit synchronous up/down counter with a parallel input register that
//   shares a 3-state I/O bus, plus a cascade terminal-count output. Intended
//   as the high byte behind an upstream 8-bit counter whose ~TC feeds cet_n.
//
// Ports
//   cp     : clock, all state changes on the rising edge
//   mr_n   : asynchronous active-low master reset (clears counter and register)
//   rld_n  : low = register captures the I/O bus on the edge
//   cld_n  : low = counter takes the register value on the edge
//   cet_n  : low = count enable (cascade input)
//   u_d    : count direction, 1 = up, 0 = down
//   oe_n   : low = drive the counter onto the I/O bus, high = bus released
//   io     : shared data bus, bit 0 is the LSB
//   tc_n   : active-low terminal count, combinational
//   vcc,gnd: supply pins, no logic function
module counter_preload_reg #(
    parameter int WIDTH = 8
) (
    input  logic             cp,
    input  logic             mr_n,
    input  logic             rld_n,
    input  logic             cld_n,
    input  logic             cet_n,
    input  logic             u_d,
    input  logic             oe_n,
    inout  wire  [WIDTH-1:0] io,
    output logic             tc_n,
    input  logic             vcc,
    input  logic             gnd
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ld_reg;
    logic [WIDTH-1:0] cnt_nxt;
    logic             at_term;

    // Supply pins carry no logic; fold them into a sink so they stay connected.
    wire unused_supply = vcc ^ gnd;

    // Next counter value: load beats count, count beats hold. Modular wrap
    // falls out of the fixed-width add/subtract.
    always_comb begin
        cnt_nxt = cnt;
        if (!cld_n)
            cnt_nxt = ld_reg;
        else if (!cet_n)
            cnt_nxt = u_d ? cnt + ONE : cnt - ONE;
    end

    // The register samples the bus itself, so with oe_n low it captures the
    // pre-edge count. The counter load uses the pre-edge register value, so a
    // simultaneous rld_n/cld_n edge loads the old register contents.
    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            cnt    <= ALL_ZERO;
            ld_reg <= ALL_ZERO;
        end else begin
            if (!rld_n)
                ld_reg <= io;
            cnt <= cnt_nxt;
        end
    end

    assign io = oe_n ? {WIDTH{1'bz}} : cnt;

    // Terminal value depends on direction so tc_n follows u_d immediately.
    assign at_term = u_d ? (cnt == ALL_ONES) : (cnt == ALL_ZERO);
    assign tc_n    = ~(~cet_n & at_term);

endmodule

// File: tb/tb_counter_preload_reg.sv
module tb_counter_preload_reg;

    logic       cp = 1'b0;
    logic       mr_n, rld_n, cld_n, cet_n, u_d, oe_n;
    logic       tc_n;
    logic       drv_en;
    logic [7:0] drv;
    wire  [7:0] bus;

    // reference state
    int cnt_m, reg_m;
    int n_pass = 0, n_chk = 0;

    assign bus = drv_en ? drv : 8'hzz;

    counter_preload_reg #(.WIDTH(8)) dut (
        .cp    (cp),
        .mr_n  (mr_n),
        .rld_n (rld_n),
        .cld_n (cld_n),
        .cet_n (cet_n),
        .u_d   (u_d),
        .oe_n  (oe_n),
        .io    (bus),
        .tc_n  (tc_n),
        .vcc   (1'b1),
        .gnd   (1'b0)
    );

    always #5 cp = ~cp;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int exp_tc();
        int term;
        term = u_d ? 255 : 0;
        return (!cet_n && cnt_m == term) ? 0 : 1;
    endfunction

    // One rising edge: update the model from the pre-edge inputs, then check.
    task automatic tick(input string tag);
        int bus_m, nc;
        @(posedge cp);
        if (mr_n) begin
            bus_m = oe_n ? int'(drv) : cnt_m;
            if (!cld_n)      nc = reg_m;
            else if (!cet_n) nc = u_d ? (cnt_m + 1) % 256 : (cnt_m + 255) % 256;
            else             nc = cnt_m;
            if (!rld_n) reg_m = bus_m;
            cnt_m = nc;
        end
        #1;
        if (!oe_n) chk({tag, "_bus"}, int'(bus), cnt_m);
        chk({tag, "_tc"}, int'(tc_n), exp_tc());
    endtask

    task automatic idle();
        rld_n = 1; cld_n = 1; cet_n = 1; u_d = 1; oe_n = 0; drv_en = 0;
    endtask

    // Register via the bus (oe_n high, tb drives), then counter load.
    task automatic load(input logic [7:0] v);
        @(negedge cp); idle(); oe_n = 1; drv_en = 1; drv = v; rld_n = 0;
        tick("ldreg");
        @(negedge cp); idle(); cld_n = 0;
        tick("ldcnt");
        @(negedge cp); idle();
    endtask

    initial begin
        drv = 8'h00;
        idle();
        mr_n = 0; cnt_m = 0; reg_m = 0;
        cet_n = 0; u_d = 1;

        // reset with clock toggling
        repeat (3) @(posedge cp);
        #1;
        chk("rst_bus", int'(bus), 0);
        chk("rst_tc_up", int'(tc_n), 1);
        u_d = 0; #1;
        chk("rst_tc_dn_cet0", int'(tc_n), 0);
        cet_n = 1; #1;
        chk("rst_tc_dn_cet1", int'(tc_n), 1);

        @(negedge cp); mr_n = 1; idle(); cet_n = 0; u_d = 1;
        tick("rel");
        chk("rel_val", int'(bus), 1);

        // register then load
        load(8'hA5);
        chk("load_a5", int'(bus), 'hA5);

        // up wrap
        load(8'hFE);
        cet_n = 0; u_d = 1;
        tick("up1");
        chk("up_ff", int'(bus), 'hFF);
        chk("up_ff_tc", int'(tc_n), 0);
        tick("up2");
        chk("up_00", int'(bus), 'h00);
        chk("up_00_tc", int'(tc_n), 1);
        load(8'hFF);
        cet_n = 1; #1;
        chk("hold_tc", int'(tc_n), 1);
        tick("hold");
        chk("hold_ff", int'(bus), 'hFF);

        // down wrap
        load(8'h01);
        cet_n = 0; u_d = 0;
        tick("dn1");
        chk("dn_00", int'(bus), 0);
        chk("dn_00_tc", int'(tc_n), 0);
        tick("dn2");
        chk("dn_ff", int'(bus), 'hFF);
        chk("dn_ff_tc", int'(tc_n), 1);

        // simultaneous rld_n/cld_n
        load(8'h3C);
        oe_n = 1; drv_en = 1; drv = 8'h77; rld_n = 0; cld_n = 0;
        tick("sim");
        @(negedge cp); idle();
        #1 chk("sim_cnt", int'(bus), 'h3C);
        cld_n = 0;
        tick("sim2");
        chk("sim_reg", int'(bus), 'h77);

        // async reset mid-count
        load(8'h41);
        cet_n = 0; u_d = 1;
        tick("cnt42");
        chk("at_42", int'(bus), 'h42);
        @(negedge cp); #1;
        mr_n = 0; cnt_m = 0; reg_m = 0; #1;
        chk("amr_bus", int'(bus), 0);
        #1 mr_n = 1;
        tick("amr_next");
        chk("amr_one", int'(bus), 1);

        // randomized
        for (int i = 0; i < 400; i++) begin
            @(negedge cp);
            oe_n   = ($urandom % 4) == 0;
            drv_en = oe_n;
            drv    = 8'($urandom);
            rld_n  = ($urandom % 3) != 0;
            cld_n  = ($urandom % 5) != 0;
            cet_n  = ($urandom % 4) == 0;
            u_d    = 1'($urandom);
            #1 chk("rnd_tc_pre", int'(tc_n), exp_tc());
            tick("rnd");
        end

        // cascade: upstream counter's ~TC drives cet_n
        load(8'h10);
        begin
            int up, hi;
            up = 250; hi = 'h10;
            for (int i = 0; i < 600; i++) begin
                @(negedge cp);
                idle();
                u_d = 1;
                cet_n = (up == 255) ? 0 : 1;
                if (up == 255) hi = (hi + 1) % 256;
                up = (up + 1) % 256;
                tick("casc");
                chk("casc_hi", int'(bus), hi);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
